// File: rtl/multiplicador_secuencial_pkg.sv
// Shared constants and state encoding for the sequential multiplier.
// Build option: define MULT_SIGNED_EN for the two's-complement Booth radix-2 datapath;
// leave it undefined for the unsigned shift-add datapath.
package multiplicador_secuencial_pkg;

  // Default operand width; the product is twice this wide.
  localparam int unsigned DefaultN = 16;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/multiplicador_secuencial.sv
// Sequential N x N -> 2N multiplier: one partial product per clock.
// Build option MULT_SIGNED_EN: defined -> signed Booth radix-2, undefined -> unsigned shift-add.
// Timing: start accepted at edge k, done strobes in the cycle after edge k+N+1, busy covers the
// N CALC cycles plus the DONE cycle. producto is held until the next result lands.
module multiplicador_secuencial
  import multiplicador_secuencial_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   multiplicando,
  input  logic [N-1:0]   multiplicador,
  output logic [2*N-1:0] producto,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CntW = $clog2(N + 1);

  state_e          state_q;
  logic [N:0]      m_q;      // multiplicand, extended to N+1 bits
  logic [N:0]      a_q;      // upper accumulator, one guard bit
  logic [N-1:0]    q_q;      // multiplier, shifted out LSB first
  logic [CntW-1:0] cnt_q;
  logic [2*N-1:0]  producto_q;
  logic            busy_q;
  logic            done_q;

  logic [N:0]      m_in;
  logic [N:0]      sum;
  logic [N:0]      a_d;
  logic [N-1:0]    q_d;

`ifdef MULT_SIGNED_EN
  logic            qm1_q;    // Booth q-1 bit
  logic            qm1_d;
`endif

  // Operand extension and one iteration of the partial-product datapath.
  always_comb begin
`ifdef MULT_SIGNED_EN
    m_in = {multiplicando[N-1], multiplicando};
    sum  = a_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase
    // Arithmetic shift right of {A,Q,q-1}.
    a_d   = {sum[N], sum[N:1]};
    q_d   = {sum[0], q_q[N-1:1]};
    qm1_d = q_q[0];
`else
    m_in = {1'b0, multiplicando};
    sum  = a_q;
    if (q_q[0]) begin
      sum = a_q + m_q;
    end
    // Logical shift right of {A,Q}; the add carry lands in A[N] and shifts down.
    a_d = {1'b0, sum[N:1]};
    q_d = {sum[0], q_q[N-1:1]};
`endif
  end

  // Controller, iteration counter, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      m_q        <= '0;
      a_q        <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      producto_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MULT_SIGNED_EN
      qm1_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            m_q     <= m_in;
            a_q     <= '0;
            q_q     <= multiplicador;
            cnt_q   <= CntW'(N);
            busy_q  <= 1'b1;
            state_q <= StCalc;
`ifdef MULT_SIGNED_EN
            qm1_q   <= 1'b0;
`endif
          end
        end
        StCalc: begin
          a_q   <= a_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CntW'(1);
`ifdef MULT_SIGNED_EN
          qm1_q <= qm1_d;
`endif
          if (cnt_q == CntW'(1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          // Low 2N bits of {A,Q}; A's guard bit only matters during iteration.
          producto_q <= {a_q[N-1:0], q_q};
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign producto = producto_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Self-checking bench for multiplicador_secuencial. Follows MULT_SIGNED_EN like the design.
module tb_multiplicador_secuencial;

  localparam int unsigned N = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [N-1:0]   multiplicando;
  logic [N-1:0]   multiplicador;
  logic [2*N-1:0] producto;
  logic           busy;
  logic           done;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  multiplicador_secuencial #(
    .N(N)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicando(multiplicando),
    .multiplicador(multiplicador),
    .producto     (producto),
    .busy         (busy),
    .done         (done)
  );

  // Reference product straight from arithmetic.
  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef MULT_SIGNED_EN
    logic signed [2*N-1:0] sa;
    logic signed [2*N-1:0] sb;
    sa = {{N{a[N-1]}}, a};
    sb = {{N{b[N-1]}}, b};
    return sa * sb;
`else
    return {{N{1'b0}}, a} * {{N{1'b0}}, b};
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a busy countdown of N+1 cycles and a pending product.
  int             m_rem  = 0;
  logic           m_done = 1'b0;
  logic [2*N-1:0] m_prod = '0;
  logic [2*N-1:0] m_pend = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_prod <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_rem == 0) begin
        if (start) begin
          m_rem  <= N + 1;
          m_pend <= ref_mul(multiplicando, multiplicador);
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_done <= 1'b1;
          m_prod <= m_pend;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_rem != 0));
      check("done", 64'(done), 64'(m_done));
      check("producto", 64'(producto), 64'(m_prod));
    end
  end

  // Called just after a posedge: pulses start for one cycle.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    start = 1'b1;
    multiplicando = a;
    multiplicador = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done; returns cycles waited and cycles with busy high.
  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cyc++;
      if (done) break;
    end
    check("done_seen", 64'(done), 64'd1);
  endtask

  task automatic do_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2*N-1:0] lit);
    int c;
    int bc;
    issue(a, b);
    wait_done(c, bc);
    check({name, "_dut"}, 64'(producto), 64'(lit));
    check({name, "_model"}, 64'(m_prod), 64'(lit));
    check({name, "_latency"}, 64'(c), 64'(N + 2));
    check({name, "_busy_cycles"}, 64'(bc), 64'(N + 1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    int bc;
    int pulses;
    logic [2*N-1:0] cap;
    logic [N-1:0] corner [4];

    reset = 1'b1;
    start = 1'b0;
    multiplicando = '0;
    multiplicador = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_producto", 64'(producto), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;

    // Hand-computed products.
`ifdef MULT_SIGNED_EN
    do_op("s_3x_m5", 16'd3, 16'hFFFB, 32'hFFFF_FFF1);
    do_op("s_min_min", 16'h8000, 16'h8000, 32'h4000_0000);
    do_op("s_min_max", 16'h8000, 16'h7FFF, 32'hC000_8000);
    do_op("s_m1_m1", 16'hFFFF, 16'hFFFF, 32'h0000_0001);
`else
    do_op("u_max_max", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    do_op("u_zero", 16'h0000, 16'h1234, 32'h0000_0000);
    do_op("u_8000_7fff", 16'h8000, 16'h7FFF, 32'h3FFF_8000);
    do_op("u_3x5", 16'd3, 16'd5, 32'h0000_000F);
`endif

    // start during CALC is ignored: one done, first operands' product.
    issue(16'd9, 16'd11);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    multiplicando = 16'd100;
    multiplicador = 16'd200;
    @(posedge clk);
    #1;
    start = 1'b0;
    pulses = 0;
    cap = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        cap = producto;
      end
    end
    check("ignored_start_pulses", 64'(pulses), 64'd1);
    check("ignored_start_prod", 64'(cap), 64'd99);
    @(posedge clk);
    #1;

    // Reset in the middle of CALC discards the partial result.
    issue(16'h1234, 16'h5678);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_producto", 64'(producto), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    do_op("after_reset_7x6", 16'd7, 16'd6, 32'h0000_002A);

    // Back-to-back with start held high.
    start = 1'b1;
    multiplicando = 16'd2;
    multiplicador = 16'd3;
    @(posedge clk);
    #1;
    multiplicando = 16'd4;
    multiplicador = 16'd5;
    wait_done(c, bc);
    check("b2b_first", 64'(producto), 64'd6);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(c, bc);
    check("b2b_spacing", 64'(c), 64'(N + 2));
    check("b2b_second", 64'(producto), 64'd20);
    @(posedge clk);
    #1;

    // Random traffic, including corner operands, stray starts and rare resets.
    corner[0] = 16'h8000;
    corner[1] = 16'h7FFF;
    corner[2] = 16'hFFFF;
    corner[3] = 16'h0000;
    for (int i = 0; i < 2000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      multiplicando = ($urandom_range(0, 5) == 0) ? corner[$urandom_range(0, 3)]
                                                  : N'($urandom);
      multiplicador = ($urandom_range(0, 5) == 0) ? corner[$urandom_range(0, 3)]
                                                  : N'($urandom);
      reset = ($urandom_range(0, 399) == 0);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    reset = 1'b0;
    repeat (N + 4) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiplicador_secuencial.md
Name: multiplicador_secuencial

Overview:
Sequential fixed-point multiplier that produces the 2N-bit product for the downstream 2N-bit pipeline register.
- Consumes two N-bit operands on a start pulse and iterates one partial product per clock.
- Result is held on producto with a one-cycle done strobe.
- Sits between the N-bit datapath (coefficient/sample registers) and the 2N-bit accumulate/hold register.

Parameters:
N, 16, operand width; instantiated with `N from constantes.h; product width is 2*N.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
multiplicando  input  N  operand A (two's complement when signed); latched on accepted start.
multiplicador  input  N  operand B; latched on accepted start.
producto  output  2N  product; registered; held until the next result completes.
busy  output  1  high in CALC and DONE.
done  output  1  one-cycle strobe; producto is valid in this cycle and held afterwards.

Behaviour:
- Reset: synchronous and active-high; the reset input is sampled only on a clk rising edge.
  - Reset values: state=IDLE, producto=0, busy=0, done=0, internal A/Q/q-1/count=0.
  - Reset has priority over everything, including mid-CALC; a partial result is discarded.
- FSM states:
  - IDLE:
    - start=1: latch M=sign-extended multiplicando (N+1 bits), Q=multiplicador, A=0, q-1=0, count=N; go to CALC.
    - start=0: stay in IDLE.
  - CALC, one Booth radix-2 step per cycle:
    - {Q[0],q-1}=01: A=A+M. =10: A=A-M. 00 or 11: no add.
    - Then arithmetic shift right of {A,Q,q-1} by 1.
    - Decrement count; when count reaches 0 after the step, go to DONE.
  - DONE: producto={A,Q}[2N-1:0]; done=1 for exactly this cycle; then go to IDLE.
- Latency:
  - start accepted at edge k; done=1 in the cycle after edge k+N+1; total N+2 cycles start-to-idle.
  - Back-to-back start is accepted in the first IDLE cycle after DONE.
- Handshake:
  - start while busy=1 is ignored; it is neither queued nor affects operands.
  - Operand inputs may change freely after acceptance.
- Arithmetic:
  - A is N+1 bits so that M=-2^(N-1) negated does not overflow; additions wrap modulo 2^(N+1).
  - The result is exact for all operand pairs; no truncation or saturation; full 2N-bit product.
- producto changes only in DONE or on reset.

Optional Feature:
MULT_SIGNED_EN
- Defined: two's-complement Booth algorithm as above.
- Undefined: unsigned shift-add.
  - Each CALC step: if Q[0]=1 then A=A+{0,multiplicando}, carry into A[N].
  - Then logical shift right of {A,Q}.
- Same latency, ports and handshake in both builds.

Decomposition:
- constantes.h holds `N and the state encodings (IDLE, CALC, DONE; 2-bit).
- No sub-module: FSM, counter and Booth datapath fit in one module.
- Counter width is clog2(N+1), computed locally.

Test Plan:
- Signed, N=16: A=3, B=-5 (0xFFFB), start pulse -> done after 18 cycles; producto=0xFFFFFFF1; busy high 17 cycles.
- Signed corner: A=B=0x8000 -> producto=0x40000000. A=0x8000, B=0x7FFF -> producto=0xC0008000.
- Unsigned build (macro undefined): A=B=0xFFFF -> producto=0xFFFE0001; A=0, B=0x1234 -> 0x00000000.
- start re-asserted, with new operands, 5 cycles into CALC -> ignored; result matches the first operands; exactly one done pulse.
- reset=1 for one cycle mid-CALC -> next cycle: producto=0, busy=0, done=0; a following start=7×6 gives 42 (0x0000002A).
- Back-to-back: start held high continuously with 2×3 then 4×5 -> done pulses N+2 cycles apart; producto=6, then 20.
